clk_div_multi: RTL
==================

// Module: clk_div_multi
// PURPOSE
//  NUM_CH-channel integer clock divider: each channel divides i_ref_clk by its own runtime ratio.
//  Ratio and enable changes are applied glitch-free at period boundaries; ratios 0/1 or disabled = bypass.
//  Sits in the clock-generation block feeding UART/peripheral domains; successor of the single-channel divider.
// PARAMETERS
//  INT_WIDTH  8  width of each channel's division ratio
//  NUM_CH     2  number of independent divided-clock channels (>=1)
// PORTS
//  i_ref_clk    in   1                 reference clock; the only clock
//  i_rst_n      in   1                 asynchronous active-low reset
//  i_clk_en     in   NUM_CH            per-channel divider enable
//  i_div_ratio  in   NUM_CH*INT_WIDTH  per-channel ratio, channel k in bits [k*INT_WIDTH +: INT_WIDTH]
//  o_div_clk    out  NUM_CH            per-channel divided clock
//  o_ratio_act  out  NUM_CH*INT_WIDTH  ratio currently applied per channel (shadow register)
//  o_div_mode   out  NUM_CH            1 = channel in divide mode, 0 = bypass
// BEHAVIOUR
//  - Reset: counters 0, div_q 0, o_ratio_act 0, o_div_mode 0; o_div_clk = i_ref_clk (bypass) on reset release.
//  - Per channel, all state on posedge i_ref_clk except the output-select flop (negedge, see below).
//  - Divide condition: en_act && ratio_act >= 2; otherwise bypass: o_div_clk = i_ref_clk.
//  - Divide mode, ratio N: period exactly N ref cycles; low phase floor(N/2), high phase ceil(N/2) cycles;
//    div_q toggles when counter == phase_len-1, counter then clears; every period starts low.
//  - Period boundary = cycle div_q falls (end of high phase). Only here are i_div_ratio/i_clk_en
//    sampled into ratio_act/en_act. While in bypass, sampling occurs every cycle.
//  - Ratio written mid-period: current period completes at old ratio; new ratio from next period; no runt pulse.
//  - i_clk_en falls mid-period: current period completes, then channel goes to bypass.
//  - Divide->bypass and bypass->divide: select flop clocked on negedge i_ref_clk, so the mux switches
//    only while i_ref_clk is low and div_q is 0 -> no glitch in either direction.
//  - Ratio max (2^INT_WIDTH-1): counter width INT_WIDTH; no overflow. Ratio 0 and 1 never enter divide mode.
//  - Channels fully independent; simultaneous updates on several channels are legal.
//  - Reset asserted mid-period: output returns to bypass asynchronously; counter, div_q and shadows clear immediately.
// CONFIGURATION
//  CLK_DIV_PULSE_EN defined: adds output o_div_pulse[NUM_CH], a one-ref-cycle registered strobe in the cycle
//    div_q rises (divide mode only; 0 in bypass and reset), for use as a synchronous clock-enable.
//  Not defined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared header clk_div_defs.vh (team shared package): INT_WIDTH default, ratio constants
//    RATIO_BYPASS_MAX=1, phase-length helper function (floor/ceil of N/2).
//  - Sub-module clk_div_channel: one counter/shadow/select/mux slice; clk_div_multi = generate loop of NUM_CH.
// TESTING (ref period 10 time units, NUM_CH=2, INT_WIDTH=8)
//  1 Reset, en=0, ratios 0 -> both o_div_clk follow i_ref_clk, o_div_mode=0, o_ratio_act=0.
//  2 ch0 en=1 ratio 4 -> after boundary, period 40, high 20, low 20; o_ratio_act[ch0]=4, o_div_mode[0]=1.
//  3 ch1 en=1 ratio 5 -> period 50, low 20, high 30; ch0 unaffected (still 40).
//  4 ch0 ratio 4->3 written mid-low-phase -> current 40 period completes, next periods 30; no pulse <10 wide.
//  5 ch0 en 1->0 mid-period, then ratio 1 with en=1 -> period finishes, clean switch to bypass, no glitch.
//  6 i_rst_n low mid-high-phase on ch1 ratio 5 -> immediate bypass, all state 0; resumes from new low phase after release.
//  Bench checks per channel: edge-to-edge period/duty monitor, min-pulse-width assertion (>=5), pulse count if CLK_DIV_PULSE_EN.

Source files
------------

// File: rtl/clk_div_multi_pkg.sv
// Shared definitions for the multi-channel clock divider.
// Default ratio width, the bypass threshold and the phase-length helpers
// used by every channel slice.
`timescale 1ns/100ps
package clk_div_multi_pkg;

    localparam int INT_WIDTH_DEF    = 8;
    // Ratios at or below this value never enter divide mode.
    localparam int RATIO_BYPASS_MAX = 1;

    // Channel operating mode; this is the state exposed on o_div_mode.
    typedef enum logic {
        MODE_BYPASS = 1'b0,
        MODE_DIVIDE = 1'b1
    } ch_mode_e;

    // Low phase length for ratio n: floor(n/2) reference cycles.
    function automatic int unsigned phase_low(input int unsigned n);
        return n >> 1;
    endfunction

    // High phase length for ratio n: ceil(n/2) reference cycles.
    function automatic int unsigned phase_high(input int unsigned n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock slice: phase counter, shadowed ratio/enable,
// negedge output-select flop and the final clock mux.
// Optional macro CLK_DIV_PULSE_EN adds div_pulse_o, a one-cycle strobe
// in the cycle div_q rises.
`timescale 1ns/100ps
module clk_div_channel
    import clk_div_multi_pkg::*;
#(
    parameter int INT_WIDTH = INT_WIDTH_DEF
) (
    input  logic                 ref_clk_i,
    input  logic                 rst_ni,
    input  logic                 clk_en_i,
    input  logic [INT_WIDTH-1:0] div_ratio_i,
`ifdef CLK_DIV_PULSE_EN
    output logic                 div_pulse_o,
`endif
    output logic                 div_clk_o,
    output logic [INT_WIDTH-1:0] ratio_act_o,
    output logic                 div_mode_o
);

    logic [INT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 div_q, div_d;
    logic [INT_WIDTH-1:0] ratio_act_q, ratio_act_d;
    logic                 en_act_q, en_act_d;
    logic                 sel_q, sel_d;
    logic [INT_WIDTH-1:0] phase_last;
    ch_mode_e             mode;

    // Mode follows only the shadow registers, so it can change solely at a
    // period boundary (or every cycle while already in bypass).
    assign mode = (en_act_q && (int'(ratio_act_q) > RATIO_BYPASS_MAX)) ? MODE_DIVIDE
                                                                        : MODE_BYPASS;

    // Last counter value of the current phase; high phase is the longer one
    // for odd ratios. Only meaningful in divide mode (ratio >= 2).
    assign phase_last = INT_WIDTH'((div_q ? phase_high(32'(ratio_act_q))
                                          : phase_low(32'(ratio_act_q))) - 32'd1);

    // Next-state: count phases in divide mode, resample shadows at the falling
    // edge of div_q, and resample every cycle while bypassed.
    always_comb begin
        cnt_d       = cnt_q;
        div_d       = div_q;
        ratio_act_d = ratio_act_q;
        en_act_d    = en_act_q;
        if (mode == MODE_BYPASS) begin
            cnt_d       = '0;
            div_d       = 1'b0;
            ratio_act_d = div_ratio_i;
            en_act_d    = clk_en_i;
        end else if (cnt_q == phase_last) begin
            cnt_d = '0;
            div_d = ~div_q;
            if (div_q) begin
                ratio_act_d = div_ratio_i;
                en_act_d    = clk_en_i;
            end
        end else begin
            cnt_d = cnt_q + INT_WIDTH'(1);
        end
    end

    // Counter, divided clock and shadow registers.
    always_ff @(posedge ref_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            div_q       <= 1'b0;
            ratio_act_q <= '0;
            en_act_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            ratio_act_q <= ratio_act_d;
            en_act_q    <= en_act_d;
        end
    end

    assign sel_d = (mode == MODE_DIVIDE);

    // Output select changes only while ref clock is low and div_q is 0,
    // so both mux inputs are low at the switch and no glitch can escape.
    always_ff @(negedge ref_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign div_clk_o   = sel_q ? div_q : ref_clk_i;
    assign ratio_act_o = ratio_act_q;
    assign div_mode_o  = (mode == MODE_DIVIDE);

`ifdef CLK_DIV_PULSE_EN
    logic pulse_q, pulse_d;
    assign pulse_d = div_d & ~div_q;

    // Registered strobe that is high in the cycle div_q is high for the first time.
    always_ff @(posedge ref_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign div_pulse_o = pulse_q;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH-channel integer clock divider driven by one reference clock.
// Each channel is an independent clk_div_channel slice.
// Optional macro CLK_DIV_PULSE_EN adds o_div_pulse[NUM_CH].
`timescale 1ns/100ps
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int INT_WIDTH = INT_WIDTH_DEF,
    parameter int NUM_CH    = 2
) (
    input  logic                        i_ref_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_CH-1:0]           i_clk_en,
    input  logic [NUM_CH*INT_WIDTH-1:0] i_div_ratio,
`ifdef CLK_DIV_PULSE_EN
    output logic [NUM_CH-1:0]           o_div_pulse,
`endif
    output logic [NUM_CH-1:0]           o_div_clk,
    output logic [NUM_CH*INT_WIDTH-1:0] o_ratio_act,
    output logic [NUM_CH-1:0]           o_div_mode
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_channel #(
            .INT_WIDTH (INT_WIDTH)
        ) u_ch (
            .ref_clk_i   (i_ref_clk),
            .rst_ni      (i_rst_n),
            .clk_en_i    (i_clk_en[k]),
            .div_ratio_i (i_div_ratio[k*INT_WIDTH +: INT_WIDTH]),
`ifdef CLK_DIV_PULSE_EN
            .div_pulse_o (o_div_pulse[k]),
`endif
            .div_clk_o   (o_div_clk[k]),
            .ratio_act_o (o_ratio_act[k*INT_WIDTH +: INT_WIDTH]),
            .div_mode_o  (o_div_mode[k])
        );
    end

endmodule
